// File: rtl/draw_pkg.sv
// Shared definitions for the note-lane frame sequencer.
//   RED / BLACK : 3-bit VGA colour codes
//   state_t     : sequencer states IDLE -> DRAW -> SHIFT -> IDLE
//   X_W / Y_W   : VGA adapter coordinate widths
//   cnt_w()     : counter width for a given range, never below 1 bit
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/note_draw_scheduler_if.sv
// Signal bundle between the note-lane sequencer, its control sources
// (rate divider, note shifter) and the VGA adapter.
//   master : the sequencer (takes enable/frame_tick/notes, drives pixel port)
//   slave  : the surrounding system
// Optional macro FRAME_OVERRUN_EN adds overrun_count[7:0].
interface note_draw_scheduler_if #(
  parameter int NUM_NOTES = 10
);
  import draw_pkg::*;

  logic                 enable;
  logic                 frame_tick;
  logic [NUM_NOTES-1:0] notes;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [2:0]           colour;
  logic                 plot;
  logic                 shift;
  logic                 busy;
  logic                 frame_done;
`ifdef FRAME_OVERRUN_EN
  logic [7:0]           overrun_count;
`endif

  modport master (
    input  enable, frame_tick, notes,
    output x, y, colour, plot, shift, busy, frame_done
`ifdef FRAME_OVERRUN_EN
    , output overrun_count
`endif
  );

  modport slave (
    output enable, frame_tick, notes,
    input  x, y, colour, plot, shift, busy, frame_done
`ifdef FRAME_OVERRUN_EN
    , input overrun_count
`endif
  );

endinterface

// File: rtl/square_raster.sv
// Column/row walker for one SQUARE_SIZE x SQUARE_SIZE square.
//   clock, reset (async, active-high), step : advance one pixel
//   col, row : current pixel within the square (col runs fastest)
//   last     : current pixel is the bottom-right one
// The counters wrap to 0 after the last pixel, so they are already at the
// origin whenever the next square (or next frame) begins.
module square_raster
  import draw_pkg::*;
#(
  parameter  int SQUARE_SIZE = 4,
  localparam int CW          = cnt_w(SQUARE_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] EDGE = CW'(SQUARE_SIZE - 1);

  assign last = (col == EDGE) && (row == EDGE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == EDGE) begin
        col <= '0;
        row <= (row == EDGE) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_draw_scheduler.sv
// Frame sequencer for the note-lane display.
// On an accepted frame tick it snapshots the notes, plots one square per slot
// (RED where a note is present, BLACK otherwise) one pixel per cycle, then
// pulses shift/frame_done for a cycle to advance the note shifter.
// Ports:
//   clock, reset (async, active-high)
//   bus (note_draw_scheduler_if.master):
//     enable, frame_tick, notes           -> in
//     x, y, colour, plot                  -> VGA adapter pixel port
//     shift, busy, frame_done             -> status / shifter control
// Optional macro FRAME_OVERRUN_EN: counts (saturating at 255) frame ticks that
// arrive while a frame is in progress, on bus.overrun_count.
module note_draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_NOTES   = 10,
  parameter int SQUARE_SIZE = 4,
  parameter int X_ORIGIN    = 0,
  parameter int X_PITCH     = 5,
  parameter int Y_ROW       = 60
) (
  input logic                 clock,
  input logic                 reset,
  note_draw_scheduler_if.master bus
);

  localparam int SW = cnt_w(NUM_NOTES);
  localparam int CW = cnt_w(SQUARE_SIZE);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_NOTES - 1);

  state_t               state, state_nxt;
  logic [SW-1:0]        slot;
  logic [NUM_NOTES-1:0] snap;
  logic [CW-1:0]        col, row;
  logic                 last;

  logic drawing, start, slot_done, frame_end;

  assign drawing   = (state == DRAW);
  assign start     = (state == IDLE) && bus.frame_tick && bus.enable;
  assign slot_done = drawing && last;
  assign frame_end = slot_done && (slot == LAST_SLOT);

  square_raster #(.SQUARE_SIZE(SQUARE_SIZE)) u_raster (
    .clock (clock),
    .reset (reset),
    .step  (drawing),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = DRAW;
      DRAW:    if (frame_end) state_nxt = SHIFT;
      SHIFT:                  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Colours come only from the snapshot, so notes may change freely mid-frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap <= '0;
      slot <= '0;
    end else if (start) begin
      snap <= bus.notes;
      slot <= '0;
    end else if (slot_done) begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    end
  end

  // Pixel port decodes only from registered state and counters.
  logic [X_W-1:0] x_pix;
  logic [Y_W-1:0] y_pix;
  logic [2:0]     colour_pix;

  always_comb begin
    x_pix      = '0;
    y_pix      = '0;
    colour_pix = BLACK;
    if (drawing) begin
      x_pix      = X_W'(X_ORIGIN) + X_W'(slot) * X_W'(X_PITCH) + X_W'(col);
      y_pix      = Y_W'(Y_ROW) + Y_W'(row);
      colour_pix = snap[slot] ? RED : BLACK;
    end
  end

  assign bus.x          = x_pix;
  assign bus.y          = y_pix;
  assign bus.colour     = colour_pix;
  assign bus.plot       = drawing;
  assign bus.shift      = (state == SHIFT);
  assign bus.frame_done = (state == SHIFT);
  assign bus.busy       = (state != IDLE);

`ifdef FRAME_OVERRUN_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overrun_q <= '0;
    else if (bus.frame_tick && (state != IDLE) && (overrun_q != 8'hFF))
      overrun_q <= overrun_q + 8'd1;
  end

  assign bus.overrun_count = overrun_q;
`else
  // Ticks arriving mid-frame are simply dropped.
`endif

endmodule

// File: tb/tb_note_draw_scheduler.sv
module tb_note_draw_scheduler;

  localparam int NUM   = 10;
  localparam int SQ    = 4;
  localparam int XO    = 0;
  localparam int PITCH = 5;
  localparam int YROW  = 60;
  localparam int FLEN  = NUM * SQ * SQ;

  logic clock;
  logic reset;
  logic run;

  note_draw_scheduler_if #(.NUM_NOTES(NUM)) bus ();

  note_draw_scheduler #(
    .NUM_NOTES(NUM), .SQUARE_SIZE(SQ), .X_ORIGIN(XO), .X_PITCH(PITCH), .Y_ROW(YROW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position mp (0 = idle, 1..FLEN = plot number,
  // FLEN+1 = shift cycle), the captured notes and the overrun count.
  int         mp;
  logic [NUM-1:0] msnap;
  int         mov;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mp = 0; msnap = '0; mov = 0;
    end else if (mp == 0) begin
      if (bus.frame_tick && bus.enable) begin
        msnap = bus.notes;
        mp    = 1;
      end
    end else begin
      if (bus.frame_tick && mov < 255) mov++;
      mp = (mp == FLEN + 1) ? 0 : mp + 1;
    end
  end

  int plot_cnt  = 0;
  int shift_cnt = 0;

  always @(negedge clock) begin
    logic [21:0] act_v, exp_v;
    int k, s, w;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    if (run) begin
      ex = 0; ey = 0; ec = 0;
      if (mp >= 1 && mp <= FLEN) begin
        k  = mp - 1;
        s  = k / (SQ * SQ);
        w  = k % (SQ * SQ);
        ex = 8'(XO + s * PITCH + w % SQ);
        ey = 7'(YROW + w / SQ);
        ec = msnap[s] ? 3'b100 : 3'b000;
      end
      exp_v = {(mp >= 1 && mp <= FLEN), ex, ey, ec, (mp == FLEN + 1), (mp != 0), (mp == FLEN + 1)};
      act_v = {bus.plot, bus.x, bus.y, bus.colour, bus.shift, bus.busy, bus.frame_done};
      chk("cycle_outputs{plot,x,y,colour,shift,busy,done}", 32'(act_v), 32'(exp_v));
`ifdef FRAME_OVERRUN_EN
      chk("cycle_overrun_count", 32'(bus.overrun_count), 32'(mov));
`endif
      if (bus.plot)  plot_cnt++;
      if (bus.shift) shift_cnt++;
    end
  end

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input int n);
    repeat (n) next_cyc();
  endtask

  // Tick is high for one cycle; on return the bench sits in plot cycle 1.
  task automatic pulse_tick();
    bus.frame_tick = 1'b1;
    next_cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 400) begin
      next_cyc();
      n++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_pix(input string name, input int px, input int py, input int pc);
    chk(name, {20'd0, bus.plot, bus.x, bus.y, bus.colour},
        {20'd0, 1'b1, 8'(px), 7'(py), 3'(pc)});
  endtask

  initial begin
    run            = 1'b0;
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.frame_tick = 1'b0;
    bus.notes      = '0;

    // 1: reset before any clock edge
    #2;
    chk("reset_outputs", {bus.plot, bus.shift, bus.busy, bus.frame_done, bus.x, bus.y, bus.colour},
        32'd0);
    run = 1'b1;
    go(2);
    reset = 1'b0;
    go(1);

    // 2: single note in slot 0
    bus.enable = 1'b1;
    bus.notes  = 10'b0000000001;
    pulse_tick();
    chk_pix("t2_plot1", 0, 60, 4);
    go(1);  chk_pix("t2_plot2", 1, 60, 4);
    go(3);  chk_pix("t2_plot5", 0, 61, 4);
    go(11); chk_pix("t2_plot16", 3, 63, 4);
    go(1);  chk_pix("t2_plot17", 5, 60, 0);
    go(143); chk_pix("t2_plot160", 48, 63, 0);
    go(1);  chk("t2_shift_161", {bus.plot, bus.shift, bus.frame_done}, 32'b011);
    go(1);  chk("t2_idle_162", {bus.busy, bus.shift}, 32'b00);

    // 3: notes cleared mid-frame; last slot keeps its snapshot colour
    bus.notes = 10'b1000000000;
    pulse_tick();
    chk_pix("t3_plot1_black", 0, 60, 0);
    go(19); bus.notes = '0;
    go(125); chk_pix("t3_plot145", 45, 60, 4);
    go(3);  chk_pix("t3_plot148", 48, 60, 4);
    wait_idle("t3_idle");

    // 4: tick while busy is dropped
    shift_cnt = 0;
    bus.notes = 10'b1010110011;
    pulse_tick();
    go(79);
    bus.frame_tick = 1'b1;
    go(1);
    bus.frame_tick = 1'b0;
    wait_idle("t4_idle");
    go(3);
    chk("t4_no_second_frame", 32'(bus.busy), 32'd0);
    chk("t4_one_shift", 32'(shift_cnt), 32'd1);
`ifdef FRAME_OVERRUN_EN
    chk("t4_overrun_count", 32'(bus.overrun_count), 32'd1);
`endif

    // 5: reset mid-frame
    bus.notes = 10'h3FF;
    pulse_tick();
    go(49);
    reset     = 1'b1;
    shift_cnt = 0;
    go(1);
    chk("t5_reset_plot_busy", {bus.plot, bus.busy}, 32'b00);
    reset = 1'b0;
    go(200);
    chk("t5_no_shift", 32'(shift_cnt), 32'd0);
    plot_cnt  = 0;
    bus.notes = 10'b0101010101;
    pulse_tick();
    chk_pix("t5_restart_plot1", 0, 60, 4);
    wait_idle("t5_idle");
    chk("t5_full_frame_plots", 32'(plot_cnt), 32'd160);
    chk("t5_full_frame_shift", 32'(shift_cnt), 32'd1);

    // 6: enable gating
    bus.enable = 1'b0;
    pulse_tick();
    chk("t6_disabled_idle", {bus.busy, bus.plot}, 32'b00);
    go(5);
    chk("t6_disabled_still_idle", 32'(bus.busy), 32'd0);
    bus.enable = 1'b1;
    shift_cnt  = 0;
    plot_cnt   = 0;
    pulse_tick();
    go(9);
    bus.enable = 1'b0;
    wait_idle("t6_idle");
    chk("t6_frame_plots", 32'(plot_cnt), 32'd160);
    chk("t6_frame_shift", 32'(shift_cnt), 32'd1);

    go(2);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
